mdio_phy_responder: RTL and testbench

//  IEEE 802.3 Clause 22 MDIO responder (PHY-side management slave) for the TSE MAC MDIO master.

---
 rtl/mdio_phy_responder.sv | 214 +++++++++++++++++++++
 tb/tb_mdio_phy_responder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_phy_responder.sv
// Clause 22 MDIO management responder (PHY side) with a small register file, oversampled on clk_clk.
// Build option: MDIO_PREAMBLE_SUPPRESS_EN lets IDLE accept ST after a single preamble 1.
module mdio_phy_responder #(
    parameter logic [4:0]  PHY_ADDR    = 5'd1,
    parameter logic [15:0] PHY_ID1     = 16'h0141,
    parameter logic [15:0] PHY_ID2     = 16'h0DD1,
    parameter int          SYNC_STAGES = 2
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       mdc,
    input  logic       mdio_in,
    output logic       mdio_out,
    output logic       mdio_oen,
    input  logic       link_up,
    output logic [1:0] speed_sel,
    output logic       wr_stb,
    output logic       frame_err
);
    localparam logic [15:0] REG0_RST = 16'h1140;
    localparam logic [15:0] REG4_RST = 16'h01E1;

    typedef enum logic [2:0] {
        S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA, S_SKIP
    } state_t;

    logic [SYNC_STAGES-1:0] mdc_sync_q, mdio_sync_q;
    logic                   mdc_prev_q;
    state_t                 state_q, state_d;
    logic [5:0]             pre_cnt_q, pre_cnt_d;
    logic [4:0]             bit_cnt_q, bit_cnt_d;
    logic                   is_read_q, is_read_d;
    logic [15:0]            shift_q, shift_d;
    logic [4:0]             regad_q, regad_d;
    logic [15:0]            rd_shift_q, rd_shift_d;
    logic [15:0]            reg0_q, reg0_d, reg4_q, reg4_d;
    logic                   mdio_out_q, mdio_out_d, mdio_oen_q, mdio_oen_d;
    logic                   wr_stb_q, wr_stb_d, frame_err_q, frame_err_d;

    logic        mdc_s, mdio_bit, mdc_rise, mdc_fall, preamble_ok;
    logic [15:0] shift_in, rd_mux;
    logic [4:0]  rd_addr;

    // Both lines go through identical synchroniser depth so their relative timing is preserved.
    assign mdc_s    = mdc_sync_q[SYNC_STAGES-1];
    assign mdio_bit = mdio_sync_q[SYNC_STAGES-1];
    assign mdc_rise = mdc_s & ~mdc_prev_q;
    assign mdc_fall = ~mdc_s & mdc_prev_q;
    assign shift_in = {shift_q[14:0], mdio_bit};
    assign rd_addr  = shift_in[4:0];

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    assign preamble_ok = (pre_cnt_q != 6'd0);
`else
    assign preamble_ok = (pre_cnt_q == 6'd32);
`endif

    always_comb begin
        case (rd_addr)
            5'd0:    rd_mux = reg0_q;
            5'd1:    rd_mux = 16'h7949 | {10'd0, link_up, 2'b00, link_up, 2'b00};
            5'd2:    rd_mux = PHY_ID1;
            5'd3:    rd_mux = PHY_ID2;
            5'd4:    rd_mux = reg4_q;
            default: rd_mux = 16'h0000;
        endcase
    end

    // NOTE: every _d gets its hold value first, so no path through this block can infer a latch.
    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        is_read_d   = is_read_q;
        shift_d     = shift_q;
        regad_d     = regad_q;
        rd_shift_d  = rd_shift_q;
        reg0_d      = reg0_q;
        reg4_d      = reg4_q;
        mdio_out_d  = mdio_out_q;
        mdio_oen_d  = mdio_oen_q;
        wr_stb_d    = 1'b0;
        frame_err_d = 1'b0;

        if (reg0_q[15]) begin
            reg0_d = REG0_RST;
            reg4_d = REG4_RST;
        end

        if (mdc_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 5'd1;
            case (state_q)
                S_IDLE: begin
                    bit_cnt_d = '0;
                    if (mdio_bit) begin
                        if (pre_cnt_q != 6'd32) pre_cnt_d = pre_cnt_q + 6'd1;
                    end else begin
                        pre_cnt_d = '0;
                        if (preamble_ok) state_d = S_ST;
                    end
                end
                S_ST: begin
                    bit_cnt_d = '0;
                    if (mdio_bit) begin
                        state_d = S_OP;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
                S_OP: if (bit_cnt_q == 5'd1) begin
                    bit_cnt_d = '0;
                    if (shift_in[1:0] == 2'b10 || shift_in[1:0] == 2'b01) begin
                        is_read_d = shift_in[1];
                        state_d   = S_PHYAD;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
                S_PHYAD: if (bit_cnt_q == 5'd4) begin
                    bit_cnt_d = '0;
                    state_d   = (shift_in[4:0] == PHY_ADDR) ? S_REGAD : S_SKIP;
                end
                S_REGAD: if (bit_cnt_q == 5'd4) begin
                    bit_cnt_d  = '0;
                    regad_d    = shift_in[4:0];
                    rd_shift_d = rd_mux;
                    state_d    = S_TA;
                end
                S_TA: if (bit_cnt_q == 5'd1) begin
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end
                S_DATA: if (bit_cnt_q == 5'd15) begin
                    bit_cnt_d = '0;
                    state_d   = S_IDLE;
                    if (!is_read_q) begin
                        case (regad_q)
                            5'd0: begin reg0_d = shift_in; wr_stb_d = 1'b1; end
                            5'd4: begin reg4_d = shift_in; wr_stb_d = 1'b1; end
                            default: ;
                        endcase
                    end
                end
                S_SKIP: if (bit_cnt_q == 5'd17) begin
                    bit_cnt_d = '0;
                    state_d   = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (mdc_fall) begin
            // The bus only changes on MDC fall so the master sees stable data at its rising edge.
            if (state_q == S_TA && is_read_q && bit_cnt_q == 5'd1) begin
                mdio_oen_d = 1'b0;
                mdio_out_d = 1'b0;
            end else if (state_q == S_DATA && is_read_q) begin
                mdio_oen_d = 1'b0;
                mdio_out_d = rd_shift_q[15];
                rd_shift_d = {rd_shift_q[14:0], 1'b0};
            end else begin
                mdio_oen_d = 1'b1;
                mdio_out_d = 1'b1;
            end
        end
    end

    // NOTE: reset is synchronous and also clears the synchronisers so no false MDC edge follows it.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            mdc_sync_q  <= '0;
            mdio_sync_q <= '1;
            mdc_prev_q  <= 1'b0;
            state_q     <= S_IDLE;
            pre_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            is_read_q   <= 1'b0;
            shift_q     <= '0;
            regad_q     <= '0;
            rd_shift_q  <= '0;
            reg0_q      <= REG0_RST;
            reg4_q      <= REG4_RST;
            mdio_out_q  <= 1'b1;
            mdio_oen_q  <= 1'b1;
            wr_stb_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            mdc_sync_q  <= {mdc_sync_q[SYNC_STAGES-2:0], mdc};
            mdio_sync_q <= {mdio_sync_q[SYNC_STAGES-2:0], mdio_in};
            mdc_prev_q  <= mdc_s;
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            is_read_q   <= is_read_d;
            shift_q     <= shift_d;
            regad_q     <= regad_d;
            rd_shift_q  <= rd_shift_d;
            reg0_q      <= reg0_d;
            reg4_q      <= reg4_d;
            mdio_out_q  <= mdio_out_d;
            mdio_oen_q  <= mdio_oen_d;
            wr_stb_q    <= wr_stb_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign mdio_out  = mdio_out_q;
    assign mdio_oen  = mdio_oen_q;
    assign wr_stb    = wr_stb_q;
    assign frame_err = frame_err_q;
    assign speed_sel = {reg0_q[6], reg0_q[13]};

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Self-checking bench for mdio_phy_responder: directed frames plus randomized frames against a register-level model.
// Honours MDIO_PREAMBLE_SUPPRESS_EN for the short-preamble expectation.
module tb_mdio_phy_responder;
    localparam int          HALF   = 6;
    localparam logic [4:0]  MY_PHY = 5'd1;

    logic       clk = 1'b0;
    logic       reset_reset, mdc, mdio_in, link_up;
    logic       mdio_out, mdio_oen, wr_stb, frame_err;
    logic [1:0] speed_sel;

    int n_checks = 0;
    int n_fail   = 0;
    int stb_cnt  = 0;
    int err_cnt  = 0;
    int drv_cnt  = 0;

    logic [15:0] m_reg0, m_reg4;

    mdio_phy_responder dut (
        .clk_clk    (clk),
        .reset_reset(reset_reset),
        .mdc        (mdc),
        .mdio_in    (mdio_in),
        .mdio_out   (mdio_out),
        .mdio_oen   (mdio_oen),
        .link_up    (link_up),
        .speed_sel  (speed_sel),
        .wr_stb     (wr_stb),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_stb)    stb_cnt <= stb_cnt + 1;
        if (frame_err) err_cnt <= err_cnt + 1;
        if (!mdio_oen) drv_cnt <= drv_cnt + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_reg0 = 16'h1140;
        m_reg4 = 16'h01E1;
    endtask

    function automatic logic [15:0] model_read(input logic [4:0] a);
        case (a)
            5'd0:    return m_reg0;
            5'd1:    return 16'h7949 | (link_up ? 16'h0024 : 16'h0000);
            5'd2:    return 16'h0141;
            5'd3:    return 16'h0DD1;
            5'd4:    return m_reg4;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic bit preamble_ok(input int n);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        return n >= 1;
`else
        return n >= 32;
`endif
    endfunction

    // One MDC period: master drives b after the fall, samples the bus just before the rise.
    task automatic mdc_cycle(input logic b, output logic seen);
        mdio_in = b;
        repeat (HALF) @(negedge clk);
        seen = mdio_oen ? 1'b1 : mdio_out;
        mdc = 1'b1;
        repeat (HALF) @(negedge clk);
        mdc = 1'b0;
    endtask

    task automatic run_frame(input int pre_len, input logic [1:0] st, input logic [1:0] op,
                             input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] wd,
                             input int abort_bit,
                             output logic ta2, output logic [15:0] rd, output logic released);
        logic s, mdrv;
        mdrv     = (op == 2'b01);
        ta2      = 1'b1;
        rd       = '0;
        released = 1'b1;
        for (int i = 0; i < pre_len; i++) mdc_cycle(1'b1, s);
        for (int i = 1; i >= 0; i--) mdc_cycle(st[i], s);
        for (int i = 1; i >= 0; i--) mdc_cycle(op[i], s);
        for (int i = 4; i >= 0; i--) mdc_cycle(phy[i], s);
        for (int i = 4; i >= 0; i--) mdc_cycle(ra[i], s);
        mdc_cycle(1'b1, s);
        mdc_cycle(mdrv ? 1'b0 : 1'b1, ta2);
        for (int i = 15; i >= 0; i--) begin
            if (i == abort_bit) begin
                mdio_in = 1'b1;
                repeat (HALF - 1) @(negedge clk);
                check("abort_driving", mdio_oen, 1'b0);
                reset_reset = 1'b1;
                @(posedge clk);
                #1;
                check("abort_oen", mdio_oen, 1'b1);
                check("abort_out", mdio_out, 1'b1);
                @(negedge clk);
                reset_reset = 1'b0;
                model_reset();
                return;
            end
            mdc_cycle(mdrv ? wd[i] : 1'b1, s);
            rd[i] = s;
        end
        repeat (HALF) @(negedge clk);
        released = mdio_oen;
    endtask

    task automatic do_txn(input string tag, input int pre_len, input logic [1:0] st,
                          input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra,
                          input logic [15:0] wd);
        int          stb0, err0, drv0;
        logic        ta2, rel;
        logic [15:0] rd, exp_rd;
        bit          pre_ok, mine, exp_stb, exp_err;
        exp_rd = model_read(ra);
        stb0   = stb_cnt;
        err0   = err_cnt;
        drv0   = drv_cnt;
        run_frame(pre_len, st, op, phy, ra, wd, -1, ta2, rd, rel);
        pre_ok  = preamble_ok(pre_len);
        mine    = pre_ok && st == 2'b01 && (op == 2'b10 || op == 2'b01) && phy == MY_PHY;
        exp_err = pre_ok && (st == 2'b00 || (st == 2'b01 && (op == 2'b00 || op == 2'b11)));
        exp_stb = 1'b0;
        if (mine && op == 2'b10) begin
            check({tag, "_ta"}, ta2, 1'b0);
            check({tag, "_data"}, rd, exp_rd);
            check({tag, "_release"}, rel, 1'b1);
        end else begin
            check({tag, "_nodrive"}, drv_cnt - drv0, 0);
        end
        if (mine && op == 2'b01 && (ra == 5'd0 || ra == 5'd4)) begin
            exp_stb = 1'b1;
            if (ra == 5'd4)    m_reg4 = wd;
            else if (wd[15])   model_reset();
            else               m_reg0 = wd;
        end
        check({tag, "_wrstb"}, stb_cnt - stb0, exp_stb);
        check({tag, "_frameerr"}, err_cnt - err0, exp_err);
        check({tag, "_speed"}, speed_sel, {m_reg0[6], m_reg0[13]});
    endtask

    initial begin
        logic        ta2, rel, is_rd;
        logic [15:0] rd;
        logic [4:0]  ra, phy;
        logic [1:0]  op, st;
        int          kind;

        reset_reset = 1'b1;
        mdc         = 1'b0;
        mdio_in     = 1'b1;
        link_up     = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        check("rst_oen", mdio_oen, 1'b1);
        check("rst_out", mdio_out, 1'b1);
        check("rst_speed", speed_sel, 2'b10);
        check("rst_wrstb", wr_stb, 1'b0);
        check("rst_frameerr", frame_err, 1'b0);
        reset_reset = 1'b0;
        repeat (2) @(negedge clk);

        do_txn("rd_id1", 32, 2'b01, 2'b10, MY_PHY, 5'd2, 16'h0000);
        do_txn("wr_r0", 32, 2'b01, 2'b01, MY_PHY, 5'd0, 16'h2100);
        do_txn("rb_r0", 32, 2'b01, 2'b10, MY_PHY, 5'd0, 16'h0000);
        do_txn("wr_r4", 32, 2'b01, 2'b01, MY_PHY, 5'd4, 16'h0DE1);
        do_txn("sw_rst", 32, 2'b01, 2'b01, MY_PHY, 5'd0, 16'h8000);
        do_txn("rb_r0d", 32, 2'b01, 2'b10, MY_PHY, 5'd0, 16'h0000);
        do_txn("rb_r4d", 32, 2'b01, 2'b10, MY_PHY, 5'd4, 16'h0000);
        do_txn("foreign", 32, 2'b01, 2'b10, 5'd3, 5'd2, 16'h0000);
        do_txn("rd_id2", 32, 2'b01, 2'b10, MY_PHY, 5'd3, 16'h0000);
        do_txn("op11", 32, 2'b01, 2'b11, 5'd31, 5'd31, 16'h0000);
        do_txn("st00", 32, 2'b00, 2'b11, 5'd31, 5'd31, 16'h0000);
        do_txn("wr_ro", 32, 2'b01, 2'b01, MY_PHY, 5'd2, 16'h1234);
        do_txn("wr_hi", 32, 2'b01, 2'b01, MY_PHY, 5'd9, 16'h5678);
        do_txn("rd_id1b", 32, 2'b01, 2'b10, MY_PHY, 5'd2, 16'h0000);
        // A complete answered frame precedes this one, so the count starts from zero here.
        do_txn("pre20", 20, 2'b01, 2'b10, MY_PHY, 5'd2, 16'h0000);
        link_up = 1'b1;
        do_txn("status", 32, 2'b01, 2'b10, MY_PHY, 5'd1, 16'h0000);
        link_up = 1'b0;
        do_txn("status0", 32, 2'b01, 2'b10, MY_PHY, 5'd1, 16'h0000);

        do_txn("wr_r0b", 32, 2'b01, 2'b01, MY_PHY, 5'd0, 16'h0040);
        run_frame(32, 2'b01, 2'b10, MY_PHY, 5'd0, 16'h0000, 8, ta2, rd, rel);
        repeat (4) @(negedge clk);
        check("abort_speed", speed_sel, 2'b10);
        do_txn("post_abort", 32, 2'b01, 2'b10, MY_PHY, 5'd0, 16'h0000);

        for (int n = 0; n < 30; n++) begin
            link_up = 1'($urandom_range(0, 1));
            kind    = $urandom_range(0, 7);
            st      = 2'b01;
            ra      = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
            phy     = MY_PHY;
            if (kind == 0) begin
                op  = 2'b10;
                phy = 5'($urandom_range(2, 31));
            end else if (kind == 1) begin
                op  = ($urandom_range(0, 1) == 0) ? 2'b11 : 2'b00;
                st  = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b01;
                if (st == 2'b00) op = 2'b11;
                phy = 5'd31;
                ra  = 5'd31;
            end else begin
                is_rd = 1'($urandom_range(0, 1));
                op    = is_rd ? 2'b10 : 2'b01;
            end
            do_txn("rand", 32, st, op, phy, ra,
                   {($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, 15'($urandom)});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
